// File: rtl/fb_sched_pkg.sv
// Shared types, defaults and pixel conversion for the framebuffer source scheduler.
package fb_sched_pkg;

    localparam int OVL_W_DEF  = 256;
    localparam int OVL_H_DEF  = 224;
    localparam int CPP_DEF    = 15;
    localparam int SAMPLE_DEF = 12;

    typedef enum logic [2:0] {
        ST_VGA       = 3'd0,
        ST_PEND_OVL  = 3'd1,
        ST_OVL_RUN   = 3'd2,
        ST_OVL_DRAIN = 3'd3,
        ST_OVL_WAIT  = 3'd4
    } sched_state_t;

    // BGR555 {x,B,G,R} to RGB666 {R,G,B}; each 5-bit channel gains a zero LSB.
    function automatic logic [17:0] bgr555_to_rgb666(input logic [15:0] c);
        logic unused_msb;
        unused_msb = c[15];
        return {c[4:0], 1'b0, c[9:5], 1'b0, c[14:10], 1'b0};
    endfunction

endpackage

// File: rtl/ovl_scan_counter.sv
// Overlay scan position: clocks-per-pixel counter plus column/row counters.
// Clear wins over run; with neither asserted everything holds.
module ovl_scan_counter #(
    parameter int OVL_W = 256,
    parameter int OVL_H = 224,
    parameter int CPP   = 15,
    localparam int CW   = $clog2(CPP)
) (
    input  logic          clk_vga,
    input  logic          resetn,
    input  logic          i_run,
    input  logic          i_clear,
    output logic [CW-1:0] o_cnt,
    output logic [7:0]    o_x,
    output logic [7:0]    o_y,
    output logic          o_frame_done
);

    logic [CW-1:0] r_cnt;
    logic [7:0]    r_x;
    logic [7:0]    r_y;
    logic          w_last_cnt;
    logic          w_last_x;
    logic          w_last_y;

    assign w_last_cnt = (r_cnt == CW'(CPP - 1));
    assign w_last_x   = (r_x == 8'(OVL_W - 1));
    assign w_last_y   = (r_y == 8'(OVL_H - 1));

    // Advance cnt every clock, x at the end of each pixel, y at the end of each line.
    always_ff @(posedge clk_vga or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_y   <= '0;
        end else if (i_run) begin
            if (w_last_cnt) begin
                r_cnt <= '0;
                if (w_last_x) begin
                    r_x <= '0;
                    if (w_last_y) r_y <= '0;
                    else          r_y <= r_y + 8'd1;
                end else begin
                    r_x <= r_x + 8'd1;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_cnt        = r_cnt;
    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_frame_done = i_run & w_last_cnt & w_last_x & w_last_y;

endmodule

// File: rtl/fb_source_scheduler.sv
// Owns the framebuffer write port and hands it between the VGA stream and the
// overlay scan, switching only on frame boundaries.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// VGA       | VGA stream drives the framebuffer
// PEND_OVL  | overlay requested, VGA continues until the next vsync edge
// OVL_RUN   | overlay scan owns the port, frames repeat
// OVL_DRAIN | overlay dropped, current overlay frame is finished first
// OVL_WAIT  | overlay frame complete, port idle until the next VGA vsync
module fb_source_scheduler
    import fb_sched_pkg::*;
#(
    parameter int OVL_W  = OVL_W_DEF,
    parameter int OVL_H  = OVL_H_DEF,
    parameter int CPP    = CPP_DEF,
    parameter int SAMPLE = SAMPLE_DEF
) (
    input  logic        clk_vga,
    input  logic        resetn,
    input  logic        vga_ce,
    input  logic        vga_de,
    input  logic        vga_vs,
    input  logic [17:0] vga_rgb,
    input  logic [10:0] vga_width,
    input  logic [9:0]  vga_height,
    input  logic        overlay_req,
    input  logic        freeze,
    input  logic [15:0] overlay_color,
    output logic [7:0]  overlay_x,
    output logic [7:0]  overlay_y,
    output logic [10:0] fb_width,
    output logic [9:0]  fb_height,
    output logic        fb_vsync,
    output logic        fb_we,
    output logic [17:0] fb_data,
    output logic        ovl_active
);

    localparam int CW = $clog2(CPP);

    sched_state_t  r_state;
    sched_state_t  w_next_state;
    logic          r_vs_d;
    logic          w_vs_rise;

    logic [CW-1:0] w_cnt;
    logic [7:0]    w_x;
    logic [7:0]    w_y;
    logic          w_frame_done;
    logic          w_scan_run;
    logic          w_scan_clear;
    logic          w_at_origin;
    logic          w_at_sample;

    logic          w_fb_we;
    logic          w_fb_vsync;
    logic [17:0]   w_fb_data;
    logic          w_ovl_next;

    logic          r_fb_we;
    logic          r_fb_vsync;
    logic [17:0]   r_fb_data;
    logic [10:0]   r_fb_width;
    logic [9:0]    r_fb_height;
    logic          r_ovl_active;

    ovl_scan_counter #(
        .OVL_W (OVL_W),
        .OVL_H (OVL_H),
        .CPP   (CPP)
    ) u_scan (
        .clk_vga      (clk_vga),
        .resetn       (resetn),
        .i_run        (w_scan_run),
        .i_clear      (w_scan_clear),
        .o_cnt        (w_cnt),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_frame_done (w_frame_done)
    );

    // The vsync edge detector samples every clock, even under freeze, so a
    // released freeze never sees a stale edge.
    always_ff @(posedge clk_vga or negedge resetn) begin
        if (!resetn) r_vs_d <= 1'b0;
        else         r_vs_d <= vga_vs;
    end

    assign w_vs_rise   = vga_vs & ~r_vs_d;
    assign w_at_origin = (w_cnt == '0) && (w_x == 8'd0) && (w_y == 8'd0);
    assign w_at_sample = (w_cnt == CW'(SAMPLE));

    // State register.
    always_ff @(posedge clk_vga or negedge resetn) begin
        if (!resetn) r_state <= ST_VGA;
        else         r_state <= w_next_state;
    end

    // Next state, scan control and next output values; freeze holds everything.
    always_comb begin
        w_next_state = r_state;
        w_fb_we      = 1'b0;
        w_fb_vsync   = 1'b0;
        w_fb_data    = r_fb_data;
        w_scan_run   = 1'b0;
        w_scan_clear = 1'b0;
        if (!freeze) begin
            unique case (r_state)
                ST_VGA: begin
                    w_fb_we    = vga_ce & vga_de;
                    w_fb_data  = vga_rgb;
                    w_fb_vsync = w_vs_rise;
                    if (overlay_req) w_next_state = ST_PEND_OVL;
                end
                ST_PEND_OVL: begin
                    w_fb_we   = vga_ce & vga_de;
                    w_fb_data = vga_rgb;
                    if (!overlay_req) begin
                        w_fb_vsync   = w_vs_rise;
                        w_next_state = ST_VGA;
                    end else if (w_vs_rise) begin
                        // This edge belongs to the overlay frame, which pulses at (0,0).
                        w_scan_clear = 1'b1;
                        w_next_state = ST_OVL_RUN;
                    end
                end
                ST_OVL_RUN, ST_OVL_DRAIN: begin
                    w_scan_run = 1'b1;
                    w_fb_vsync = w_at_origin;
                    if (w_at_sample) begin
                        w_fb_we   = 1'b1;
                        w_fb_data = bgr555_to_rgb666(overlay_color);
                    end
                    if (overlay_req) begin
                        w_next_state = ST_OVL_RUN;
                    end else if (w_frame_done) begin
                        w_next_state = ST_OVL_WAIT;
                    end else begin
                        w_next_state = ST_OVL_DRAIN;
                    end
                end
                ST_OVL_WAIT: begin
                    w_scan_clear = 1'b1;
                    if (overlay_req) begin
                        w_next_state = ST_OVL_RUN;
                    end else if (w_vs_rise) begin
                        w_fb_vsync   = 1'b1;
                        w_next_state = ST_VGA;
                    end
                end
                default: w_next_state = ST_VGA;
            endcase
        end
    end

    assign w_ovl_next = (w_next_state == ST_OVL_RUN)   ||
                        (w_next_state == ST_OVL_DRAIN) ||
                        (w_next_state == ST_OVL_WAIT);

    // Output registers; geometry follows the state being entered so it lines up with the state register.
    always_ff @(posedge clk_vga or negedge resetn) begin
        if (!resetn) begin
            r_fb_we      <= 1'b0;
            r_fb_vsync   <= 1'b0;
            r_fb_data    <= '0;
            r_fb_width   <= '0;
            r_fb_height  <= '0;
            r_ovl_active <= 1'b0;
        end else begin
            r_fb_we      <= w_fb_we;
            r_fb_vsync   <= w_fb_vsync;
            r_fb_data    <= w_fb_data;
            r_fb_width   <= w_ovl_next ? 11'(OVL_W) : vga_width;
            r_fb_height  <= w_ovl_next ? 10'(OVL_H) : vga_height;
            r_ovl_active <= w_ovl_next;
        end
    end

    assign overlay_x  = w_x;
    assign overlay_y  = w_y;
    assign fb_we      = r_fb_we;
    assign fb_vsync   = r_fb_vsync;
    assign fb_data    = r_fb_data;
    assign fb_width   = r_fb_width;
    assign fb_height  = r_fb_height;
    assign ovl_active = r_ovl_active;

endmodule

// File: tb/tb_fb_source_scheduler.sv
// Scoreboard bench: stimulus queues expected vsync/write events, a negedge
// monitor pops and compares each one the DUT presents.
module tb_fb_source_scheduler;

    localparam int TW = 8;
    localparam int TH = 6;

    logic        clk_vga = 1'b0;
    logic        resetn  = 1'b1;
    logic        vga_ce = 1'b0, vga_de = 1'b0, vga_vs = 1'b0;
    logic [17:0] vga_rgb = '0;
    logic [10:0] vga_width = 11'd640;
    logic [9:0]  vga_height = 10'd480;
    logic        overlay_req = 1'b0, freeze = 1'b0;
    logic [15:0] overlay_color;
    logic [7:0]  overlay_x, overlay_y;
    logic [10:0] fb_width;
    logic [9:0]  fb_height;
    logic        fb_vsync, fb_we, ovl_active;
    logic [17:0] fb_data;

    logic        pat_mode = 1'b0;

    fb_source_scheduler #(.OVL_W(TW), .OVL_H(TH), .CPP(15), .SAMPLE(12)) dut (
        .clk_vga(clk_vga), .resetn(resetn), .vga_ce(vga_ce), .vga_de(vga_de),
        .vga_vs(vga_vs), .vga_rgb(vga_rgb), .vga_width(vga_width),
        .vga_height(vga_height), .overlay_req(overlay_req), .freeze(freeze),
        .overlay_color(overlay_color), .overlay_x(overlay_x), .overlay_y(overlay_y),
        .fb_width(fb_width), .fb_height(fb_height), .fb_vsync(fb_vsync),
        .fb_we(fb_we), .fb_data(fb_data), .ovl_active(ovl_active)
    );

    always #5 clk_vga = ~clk_vga;

    // Overlay source pattern, a distinct colour per (x,y).
    function automatic logic [4:0] pat_r(input logic [7:0] x, input logic [7:0] y);
        int v;
        v = int'(x) + 4 * int'(y) + 1;
        return v[4:0];
    endfunction
    function automatic logic [4:0] pat_g(input logic [7:0] x);
        int v;
        v = 3 * int'(x);
        return v[4:0];
    endfunction
    function automatic logic [4:0] pat_b(input logic [7:0] y);
        int v;
        v = int'(y) + 5;
        return v[4:0];
    endfunction

    assign overlay_color = pat_mode ? {1'b0, pat_b(overlay_y), pat_g(overlay_x), pat_r(overlay_x, overlay_y)}
                                    : 16'h7C1F;

    typedef struct {
        bit          is_vs;
        logic [17:0] data;
        logic [10:0] w;
        logic [9:0]  h;
        int          gap;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0, errors = 0;
    int   n_we = 0, pushed_we = 0;
    int   cyc = 0, last_we = -1;
    int   base, base4, hn;
    logic [7:0] hx, hy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_vga);
        #1;
    endtask

    task automatic push_vs(input logic [10:0] w, input logic [9:0] h);
        exp_t e;
        e.is_vs = 1'b1; e.data = '0; e.w = w; e.h = h; e.gap = 0;
        sb.push_back(e);
    endtask

    task automatic push_we(input logic [17:0] d, input int gap);
        exp_t e;
        e.is_vs = 1'b0; e.data = d; e.w = '0; e.h = '0; e.gap = gap;
        sb.push_back(e);
        pushed_we++;
    endtask

    // One overlay frame: vsync then TW*TH writes in raster order.
    task automatic push_frame(input bit pat, input bit gapchk);
        push_vs(11'(TW), 10'(TH));
        for (int y = 0; y < TH; y++)
            for (int x = 0; x < TW; x++) begin
                logic [7:0] xb, yb;
                xb = 8'(x); yb = 8'(y);
                push_we(pat ? {pat_r(xb, yb), 1'b0, pat_g(xb), 1'b0, pat_b(yb), 1'b0} : 18'h3E03E,
                        (gapchk && !(x == 0 && y == 0)) ? 15 : 0);
            end
    endtask

    task automatic vga_pixel(input logic [17:0] d);
        vga_ce = 1'b1; vga_de = 1'b1; vga_rgb = d;
        push_we(d, 0);
        tick;
        vga_ce = 1'b0; vga_de = 1'b0;
    endtask

    task automatic vs_pulse;
        vga_vs = 1'b1; tick;
        vga_vs = 1'b0; tick;
    endtask

    task automatic wait_we(input int target, input int budget);
        int k;
        k = 0;
        while (n_we < target && k < budget) begin
            tick;
            k++;
        end
        check("wait_we_reached", 32'(n_we >= target), 1);
    endtask

    always @(posedge clk_vga) cyc++;

    // Monitor: every vsync/write the DUT presents must match the queue head.
    always @(negedge clk_vga) begin
        if (resetn) begin
            if (fb_vsync) begin
                if (sb.size() == 0) check("unexpected_vsync", 1, 0);
                else begin
                    me = sb.pop_front();
                    check("vs_kind", 32'(me.is_vs), 1);
                    check("vs_width", 32'(fb_width), 32'(me.w));
                    check("vs_height", 32'(fb_height), 32'(me.h));
                end
            end
            if (fb_we) begin
                n_we++;
                if (sb.size() == 0) check("unexpected_we", 1, 0);
                else begin
                    me = sb.pop_front();
                    check("we_kind", 32'(me.is_vs), 0);
                    check("we_data", 32'(fb_data), 32'(me.data));
                    if (me.gap != 0) check("we_gap", 32'(cyc - last_we), 32'(me.gap));
                end
                last_we = cyc;
            end
        end
    end

    initial begin
        // Reset state
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk_vga);
        #1;
        check("rst_we", 32'(fb_we), 0);
        check("rst_vsync", 32'(fb_vsync), 0);
        check("rst_data", 32'(fb_data), 0);
        check("rst_width", 32'(fb_width), 0);
        check("rst_height", 32'(fb_height), 0);
        check("rst_xy", 32'({overlay_x, overlay_y}), 0);
        check("rst_active", 32'(ovl_active), 0);
        resetn = 1'b1;
        tick;
        check("vga_width_out", 32'(fb_width), 640);
        check("vga_height_out", 32'(fb_height), 480);

        // VGA pass-through
        push_vs(11'd640, 10'd480);
        vs_pulse;
        vga_pixel(18'h12345);
        check("vga_latency_we", 32'(fb_we), 1);
        check("vga_latency_data", 32'(fb_data), 32'h12345);
        vga_pixel(18'h0ABCD);
        vga_de = 1'b1; tick; vga_de = 1'b0;
        vga_pixel(18'h3FFFF);

        // Overlay entry: VGA continues in PEND, switch on the next vs edge
        overlay_req = 1'b1;
        tick;
        vga_pixel(18'h01111);
        vga_pixel(18'h02222);
        tick;
        base = pushed_we;
        push_frame(1'b0, 1'b1);
        push_frame(1'b1, 1'b1);
        push_frame(1'b1, 1'b1);
        vga_vs = 1'b1; tick;
        check("entry_active", 32'(ovl_active), 1);
        check("entry_width", 32'(fb_width), TW);
        check("entry_height", 32'(fb_height), TH);
        check("entry_no_vga_vs", 32'(fb_vsync), 0);
        vga_vs = 1'b0;
        wait_we(base + 48, 1500);
        pat_mode = 1'b1;

        // Drain, cancel by re-raise, drain again to WAIT
        wait_we(base + 96 + 20, 1500);
        overlay_req = 1'b0;
        repeat (30) tick;
        check("drain_active", 32'(ovl_active), 1);
        overlay_req = 1'b1;
        wait_we(base + 96 + 40, 1500);
        overlay_req = 1'b0;
        wait_we(base + 144, 1500);
        repeat (20) tick;
        check("wait_active", 32'(ovl_active), 1);
        check("wait_xy", 32'({overlay_x, overlay_y}), 0);
        check("wait_width", 32'(fb_width), TW);
        push_vs(11'd640, 10'd480);
        vs_pulse;
        check("exit_active", 32'(ovl_active), 0);
        check("exit_width", 32'(fb_width), 640);
        vga_pixel(18'h15555);

        // PEND cancel: no overlay traffic
        overlay_req = 1'b1;
        repeat (3) tick;
        overlay_req = 1'b0;
        repeat (2) tick;
        check("pend_cancel_active", 32'(ovl_active), 0);
        push_vs(11'd640, 10'd480);
        vs_pulse;
        vga_pixel(18'h2ABCD);

        // Same-clock request and vs edge: VGA frame pulse, switch on the following edge
        push_vs(11'd640, 10'd480);
        base4 = pushed_we;
        push_frame(1'b1, 1'b0);
        overlay_req = 1'b1; vga_vs = 1'b1; tick;
        vga_vs = 1'b0; tick; tick;
        check("same_clk_pend_active", 32'(ovl_active), 0);
        vs_pulse;
        wait_we(base4 + 10, 1500);

        // Freeze across a vs edge
        freeze = 1'b1;
        tick; tick;
        hx = overlay_x; hy = overlay_y; hn = n_we;
        repeat (300) tick;
        vga_vs = 1'b1;
        repeat (696) tick;
        check("freeze_no_we", 32'(n_we), 32'(hn));
        check("freeze_x_held", 32'(overlay_x), 32'(hx));
        check("freeze_y_held", 32'(overlay_y), 32'(hy));
        freeze = 1'b0;
        repeat (5) tick;
        vga_vs = 1'b0;
        wait_we(base4 + 30, 1500);

        // Async reset between clock edges mid-overlay
        @(posedge clk_vga);
        #3 resetn = 1'b0;
        #1;
        check("arst_we_vs", 32'({fb_we, fb_vsync}), 0);
        check("arst_data", 32'(fb_data), 0);
        check("arst_geom", 32'({fb_width, fb_height}), 0);
        check("arst_xy", 32'({overlay_x, overlay_y}), 0);
        check("arst_active", 32'(ovl_active), 0);
        sb.delete();
        overlay_req = 1'b0;
        pat_mode = 1'b0;
        repeat (2) @(posedge clk_vga);
        #1 resetn = 1'b1;
        tick;
        check("post_rst_active", 32'(ovl_active), 0);
        check("post_rst_width", 32'(fb_width), 640);
        push_vs(11'd640, 10'd480);
        vs_pulse;
        vga_pixel(18'h0F0F0);
        repeat (5) tick;
        check("sb_empty", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
